// File: rtl/digit_scan_decoder_pkg.sv
// Shared display constants and the active-low one-hot helper used by the digit
// decoder and by the segment-mux logic.
package digit_scan_decoder_pkg;

  localparam int unsigned MAX_DIGITS     = 16;
  localparam int unsigned DIGITS_DEFAULT = 4;
  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned DIGIT_HZ       = 1_000;
  localparam int unsigned DIV_DEFAULT    = CLK_HZ / DIGIT_HZ;
  localparam int unsigned BLANK_DEFAULT  = 2;

  // Active-low one-hot of idx within width bits; an out-of-range idx yields all ones.
  function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx,
                                                     input int unsigned width);
    logic [MAX_DIGITS-1:0] res;
    res = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < width && i == idx) res[i] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/digit_scan_decoder_scan_prescaler.sv
// Slot prescaler: counts clk cycles within a digit slot and flags the last one.
module digit_scan_decoder_scan_prescaler #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic slotEnd_c
);

  localparam int unsigned PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV - 1);

  logic [PCNT_W-1:0] pcnt;

  assign slotEnd_c = !clear && !hold && (pcnt == PCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (!hold) begin
      pcnt <= slotEnd_c ? '0 : pcnt + PCNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_decoder.sv
// Digit-select decoder for the multiplexed display: direct decode or autonomous
// scan with an all-off blank interval at every digit change.
module digit_scan_decoder
  import digit_scan_decoder_pkg::*;
#(
  parameter  int unsigned DIGITS    = DIGITS_DEFAULT,
  parameter  int unsigned DIV       = DIV_DEFAULT,
  parameter  int unsigned BLANK_CYC = BLANK_DEFAULT,
  localparam int unsigned SEL_W     = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode_direct,
  input  logic [SEL_W-1:0]  dir_sel,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [DIGITS-1:0] dig_n,
  output logic [SEL_W-1:0]  sel,
  output logic              scan_tick
);

  // One spare bit so "bcnt <= 1" is never a width-constant comparison.
  localparam int unsigned BCNT_W = $clog2(BLANK_CYC + 2) + 1;
  localparam logic [BCNT_W-1:0] BLANK_INIT = BCNT_W'(BLANK_CYC);

  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcntNext;
  logic [SEL_W-1:0]  selNext;
  logic [DIGITS-1:0] digNNext;
  logic              tickNext;
  logic              slotEnd;
  logic              scanRun;

  function automatic logic [DIGITS-1:0] decodeN(input logic [SEL_W-1:0]  idx,
                                                input logic [DIGITS-1:0] mask);
    logic [MAX_DIGITS-1:0] full;
    logic [DIGITS-1:0]     res;
    full = onehot_n(32'(idx), DIGITS);
    res  = full[DIGITS-1:0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (32'(idx) == i && mask[i]) res = '1;
    end
    return res;
  endfunction

  function automatic logic inRange(input logic [SEL_W-1:0] idx);
    logic [MAX_DIGITS-1:0] full;
    full = onehot_n(32'(idx), DIGITS);
    return full[DIGITS-1:0] != '1;
  endfunction

  assign scanRun = en && !mode_direct;

  digit_scan_decoder_scan_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!scanRun),
    .hold     (1'b0),
    .slotEnd_c(slotEnd)
  );

  // State register: reset behaves as a slot start, so bcnt begins full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      bcnt      <= BLANK_INIT;
      dig_n     <= '1;
      scan_tick <= 1'b0;
    end else begin
      sel       <= selNext;
      bcnt      <= bcntNext;
      dig_n     <= digNNext;
      scan_tick <= tickNext;
    end
  end

  // Next state: disable, direct load and slot change all restart the blank interval.
  always_comb begin
    selNext  = sel;
    bcntNext = bcnt;
    if (!en) begin
      bcntNext = BLANK_INIT;
    end else if (mode_direct) begin
      selNext  = inRange(dir_sel) ? dir_sel : '0;
      bcntNext = BLANK_INIT;
    end else if (slotEnd) begin
      selNext  = (sel == SEL_W'(DIGITS - 1)) ? '0 : sel + SEL_W'(1);
      bcntNext = BLANK_INIT;
    end else if (bcnt != '0) begin
      bcntNext = bcnt - BCNT_W'(1);
    end
  end

  // Next outputs: the slot-change edge is the first blank cycle unless BLANK_CYC is 0.
  always_comb begin
    digNNext = '1;
    tickNext = 1'b0;
    if (en) begin
      if (mode_direct) begin
        digNNext = decodeN(dir_sel, blank_mask);
      end else begin
        tickNext = slotEnd;
        if (slotEnd ? (BLANK_CYC == 0) : (bcnt <= BCNT_W'(1))) begin
          digNNext = decodeN(selNext, blank_mask);
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Self-checking bench: two decoder instances against a slot/age reference model.
module tb_digit_scan_decoder;

  logic       clk;
  logic       rst_n;

  logic       enA, modeA, tickA;
  logic [1:0] dirSelA, selA;
  logic [3:0] maskA, digA;

  logic       enB, modeB, tickB;
  logic [2:0] dirSelB, selB;
  logic [4:0] maskB, digB;

  int nCmp = 0;
  int nBad = 0;

  // Model: each unit tracks its digit and the age (edges) since its slot began.
  int pDig[2] = '{4, 5};
  int pDiv[2] = '{8, 2};
  int pBlk[2] = '{2, 0};
  int mSel[2];
  int mAge[2];
  int expDig[2];
  int expTick[2];

  digit_scan_decoder #(.DIGITS(4), .DIV(8), .BLANK_CYC(2)) dutA (
    .clk(clk), .rst_n(rst_n), .en(enA), .mode_direct(modeA), .dir_sel(dirSelA),
    .blank_mask(maskA), .dig_n(digA), .sel(selA), .scan_tick(tickA)
  );

  digit_scan_decoder #(.DIGITS(5), .DIV(2), .BLANK_CYC(0)) dutB (
    .clk(clk), .rst_n(rst_n), .en(enB), .mode_direct(modeB), .dir_sel(dirSelB),
    .blank_mask(maskB), .dig_n(digB), .sel(selB), .scan_tick(tickB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ones(input int d);
    return (1 << d) - 1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mSel[u] = 0; mAge[u] = 0; expTick[u] = 0; expDig[u] = ones(pDig[u]);
    end
  endtask

  task automatic model_edge(input int u, input bit e, input bit m, input int ds, input int mk);
    int d;
    d = pDig[u];
    if (!e) begin
      mAge[u] = 0; expTick[u] = 0; expDig[u] = ones(d);
    end else if (m) begin
      mAge[u] = 0; expTick[u] = 0;
      if (ds < d) begin
        mSel[u] = ds;
        expDig[u] = ((mk >> ds) & 1) != 0 ? ones(d) : (ones(d) & ~(1 << ds));
      end else begin
        mSel[u] = 0; expDig[u] = ones(d);
      end
    end else begin
      if (mAge[u] == pDiv[u] - 1) begin
        mSel[u] = (mSel[u] + 1) % d; mAge[u] = 0; expTick[u] = 1;
      end else begin
        mAge[u]++; expTick[u] = 0;
      end
      expDig[u] = (mAge[u] >= pBlk[u] && ((mk >> mSel[u]) & 1) == 0)
                  ? (ones(d) & ~(1 << mSel[u])) : ones(d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, enA, modeA, int'(dirSelA), int'(maskA));
      model_edge(1, enB, modeB, int'(dirSelB), int'(maskB));
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enA = 1'b1; modeA = 1'b0; dirSelA = '0; maskA = '0;
    enB = 1'b0; modeB = 1'b0; dirSelB = '0; maskB = '0;
    #22;
    nCmp++;
    if (digA !== 4'hF || selA !== 2'd0 || tickA !== 1'b0) begin
      nBad++; $display("FAIL reset_A dig_n=%b sel=%0d tick=%b want 1111/0/0", digA, selA, tickA);
    end
    nCmp++;
    if (digB !== 5'h1F || selB !== 3'd0 || tickB !== 1'b0) begin
      nBad++; $display("FAIL reset_B dig_n=%b sel=%0d tick=%b want 11111/0/0", digB, selB, tickB);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] want;
    bit         have;
    for (int e = 1; e <= 40; e++) begin
      step();
      nCmp++;
      if (digA !== 4'(expDig[0]) || selA !== 2'(mSel[0]) || tickA !== 1'(expTick[0])) begin
        nBad++; $display("FAIL scan_model e=%0d dig_n=%b sel=%0d tick=%b want %b/%0d/%0d",
                         e, digA, selA, tickA, 4'(expDig[0]), mSel[0], expTick[0]);
      end
      have = 1'b1;
      case (e)
        1, 8, 9:         want = 4'b1111;
        2, 7, 34:        want = 4'b1110;
        10:              want = 4'b1101;
        18:              want = 4'b1011;
        26:              want = 4'b0111;
        default:         begin want = 4'b1111; have = 1'b0; end
      endcase
      if (have) begin
        nCmp++;
        if (digA !== want) begin
          nBad++; $display("FAIL scan_seq e=%0d dig_n=%b want %b", e, digA, want);
        end
      end
      if (e == 8) begin
        nCmp++;
        if (tickA !== 1'b1 || selA !== 2'd1) begin
          nBad++; $display("FAIL scan_first_tick tick=%b sel=%0d want 1/1", tickA, selA);
        end
      end
    end
  endtask

  task automatic test_mask();
    maskA = 4'b0100;
    for (int e = 0; e < 40; e++) begin
      step();
      nCmp++;
      if (digA !== 4'(expDig[0]) || selA !== 2'(mSel[0]) || tickA !== 1'(expTick[0])) begin
        nBad++; $display("FAIL mask_model dig_n=%b sel=%0d tick=%b want %b/%0d/%0d",
                         digA, selA, tickA, 4'(expDig[0]), mSel[0], expTick[0]);
      end
      nCmp++;
      if (digA === 4'b1011) begin
        nBad++; $display("FAIL mask_digit2 dig_n=%b want not 1011", digA);
      end
    end
    maskA = 4'b0000;
  endtask

  task automatic test_direct();
    logic [3:0] tbl[4];
    tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    modeA = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dirSelA = 2'(k);
      step();
      nCmp++;
      if (digA !== tbl[k] || selA !== 2'(k) || tickA !== 1'b0) begin
        nBad++; $display("FAIL direct_A k=%0d dig_n=%b sel=%0d tick=%b want %b/%0d/0",
                         k, digA, selA, tickA, tbl[k], k);
      end
    end
    maskA = 4'b0010; dirSelA = 2'd1;
    step();
    nCmp++;
    if (digA !== 4'b1111) begin
      nBad++; $display("FAIL direct_masked dig_n=%b want 1111", digA);
    end
    maskA = 4'b0000;
    enB = 1'b1; modeB = 1'b1; dirSelB = 3'd7;
    step();
    nCmp++;
    if (digB !== 5'b11111 || tickB !== 1'b0) begin
      nBad++; $display("FAIL direct_out_of_range dig_n=%b tick=%b want 11111/0", digB, tickB);
    end
    dirSelB = 3'd4;
    step();
    nCmp++;
    if (digB !== 5'b01111 || selB !== 3'd4) begin
      nBad++; $display("FAIL direct_B_top dig_n=%b sel=%0d want 01111/4", digB, selB);
    end
  endtask

  task automatic test_en_drop();
    int  guard;
    logic [3:0] want;
    modeA = 1'b0;
    guard = 0;
    while (!(mSel[0] == 1 && mAge[0] == 5) && guard < 200) begin
      step(); guard++;
      nCmp++;
      if (digA !== 4'(expDig[0]) || selA !== 2'(mSel[0])) begin
        nBad++; $display("FAIL en_drop_lead dig_n=%b sel=%0d want %b/%0d",
                         digA, selA, 4'(expDig[0]), mSel[0]);
      end
    end
    nCmp++;
    if (guard >= 200) begin
      nBad++; $display("FAIL en_drop_reach_slot waited=%0d want <200", guard);
    end
    enA = 1'b0;
    step();
    nCmp++;
    if (digA !== 4'b1111 || selA !== 2'd1 || tickA !== 1'b0) begin
      nBad++; $display("FAIL en_low dig_n=%b sel=%0d tick=%b want 1111/1/0", digA, selA, tickA);
    end
    enA = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      want = (j >= 1 && j <= 6) ? 4'b1101 : 4'b1111;
      nCmp++;
      if (digA !== want || digA !== 4'(expDig[0])) begin
        nBad++; $display("FAIL en_return j=%0d dig_n=%b want %b", j, digA, want);
      end
      if (j == 7) begin
        nCmp++;
        if (tickA !== 1'b1 || selA !== 2'd2) begin
          nBad++; $display("FAIL en_return_tick tick=%b sel=%0d want 1/2", tickA, selA);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int  guard;
    logic [3:0] want;
    guard = 0;
    while (!(mSel[0] == 2 && mAge[0] == 4) && guard < 200) begin
      step(); guard++;
    end
    nCmp++;
    if (guard >= 200 || digA !== 4'b1011) begin
      nBad++; $display("FAIL async_pre_drive dig_n=%b waited=%0d want 1011", digA, guard);
    end
    #3;
    rst_n = 1'b0;
    #1;
    nCmp++;
    if (digA !== 4'hF || selA !== 2'd0 || tickA !== 1'b0 || digB !== 5'h1F) begin
      nBad++; $display("FAIL async_reset_now dig_n=%b sel=%0d tick=%b digB=%b want 1111/0/0/11111",
                       digA, selA, tickA, digB);
    end
    model_reset();
    step(); step();
    nCmp++;
    if (digA !== 4'hF || selA !== 2'd0) begin
      nBad++; $display("FAIL async_reset_hold dig_n=%b sel=%0d want 1111/0", digA, selA);
    end
    #4;
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      want = (e >= 2 && e <= 7) ? 4'b1110 : (e == 10 ? 4'b1101 : 4'b1111);
      nCmp++;
      if (digA !== want || digA !== 4'(expDig[0]) || tickA !== 1'(e == 8)) begin
        nBad++; $display("FAIL async_release e=%0d dig_n=%b tick=%b want %b/%0d",
                         e, digA, tickA, want, (e == 8));
      end
    end
  endtask

  task automatic test_blank0();
    modeB = 1'b0; maskB = '0;
    for (int e = 0; e < 20; e++) begin
      step();
      nCmp++;
      if (digB !== 5'(expDig[1]) || selB !== 3'(mSel[1]) || tickB !== 1'(expTick[1])) begin
        nBad++; $display("FAIL blank0_model dig_n=%b sel=%0d tick=%b want %b/%0d/%0d",
                         digB, selB, tickB, 5'(expDig[1]), mSel[1], expTick[1]);
      end
      nCmp++;
      if ($countones(~digB) != 1) begin
        nBad++; $display("FAIL blank0_no_gap dig_n=%b want exactly one low bit", digB);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prevDigA;
    bit         prevScan;
    int         hold;
    prevDigA = digA; prevScan = 1'b0;
    for (int it = 0; it < 100; it++) begin
      enA     = ($urandom_range(0, 7) != 0);
      modeA   = ($urandom_range(0, 3) == 0);
      maskA   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      dirSelA = 2'($urandom);
      enB     = ($urandom_range(0, 7) != 0);
      modeB   = ($urandom_range(0, 3) == 0);
      maskB   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
      dirSelB = 3'($urandom_range(0, 4));
      hold    = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        step();
        nCmp++;
        if (digA !== 4'(expDig[0]) || selA !== 2'(mSel[0]) || tickA !== 1'(expTick[0])) begin
          nBad++; $display("FAIL rand_A it=%0d dig_n=%b sel=%0d tick=%b want %b/%0d/%0d",
                           it, digA, selA, tickA, 4'(expDig[0]), mSel[0], expTick[0]);
        end
        nCmp++;
        if (digB !== 5'(expDig[1]) || selB !== 3'(mSel[1]) || tickB !== 1'(expTick[1])) begin
          nBad++; $display("FAIL rand_B it=%0d dig_n=%b sel=%0d tick=%b want %b/%0d/%0d",
                           it, digB, selB, tickB, 5'(expDig[1]), mSel[1], expTick[1]);
        end
        nCmp++;
        if ($countones(~digA) > 1 || $countones(~digB) > 1) begin
          nBad++; $display("FAIL rand_onehot digA=%b digB=%b want at most one low bit", digA, digB);
        end
        if (prevScan && enA && !modeA) begin
          nCmp++;
          if (prevDigA != 4'hF && digA != 4'hF && digA != prevDigA) begin
            nBad++; $display("FAIL rand_ghost prev=%b now=%b want a 1111 between digits",
                             prevDigA, digA);
          end
        end
        prevDigA = digA;
        prevScan = enA && !modeA;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mask();
    test_direct();
    test_en_drop();
    test_async_reset();
    test_blank0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
